// File: rtl/sirv_spigpio_pkg.sv
// sirv_spigpio_pkg -- shared definitions for the SPI/GPIO pad port.
//   lane_state_e : per-lane direction FSM encoding (IN / OUT / TURN).
//   *_MIN/*_MAX  : legal ranges for the port parameters.
//   dq_w_legal   : helper telling whether a lane count is a supported width.
// Optional feature macro used by the port: SIRV_SPIGPIOPORT_LOOPBACK_EN.
package sirv_spigpio_pkg;

  typedef enum logic [1:0] {
    LANE_IN   = 2'b00,
    LANE_OUT  = 2'b01,
    LANE_TURN = 2'b10
  } lane_state_e;

  localparam int DQ_W_MAX     = 8;
  localparam int CS_W_MIN     = 1;
  localparam int CS_W_MAX     = 4;
  localparam int TURN_CYC_MIN = 0;
  localparam int TURN_CYC_MAX = 7;
  localparam int SYNC_MIN     = 1;
  localparam int SYNC_MAX     = 4;

  function automatic logic dq_w_legal(input int w);
    return (w == 1) || (w == 2) || (w == 4) || (w == DQ_W_MAX);
  endfunction

endpackage

// File: rtl/sirv_spigpio_lane.sv
// sirv_spigpio_lane -- one dq lane: direction FSM with turnaround plus the
// input synchronizer.
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   oe_req_i            direction request from the controller (1 = drive)
//   ival_i              pad input value
//   lb_en_i, lb_data_i  loopback select and data (SIRV_SPIGPIOPORT_LOOPBACK_EN only)
//   oe_o, ie_o, turn_o  registered pad direction controls / turnaround flag
//   data_o              synchronized input, zero unless the lane is in IN
module sirv_spigpio_lane
  import sirv_spigpio_pkg::*;
#(
  parameter int TURN_CYC    = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic oe_req_i,
  input  logic ival_i,
`ifdef SIRV_SPIGPIOPORT_LOOPBACK_EN
  input  logic lb_en_i,
  input  logic lb_data_i,
`endif
  output logic oe_o,
  output logic ie_o,
  output logic turn_o,
  output logic data_o
);

  // Counter is loaded with TURN_CYC-1 so TURN lasts exactly TURN_CYC cycles.
  localparam logic [2:0] TURN_LOAD = (TURN_CYC == 0) ? 3'd0 : 3'(TURN_CYC - 1);

  lane_state_e             state_q, state_d;
  lane_state_e             tgt_q, tgt_d;
  logic [2:0]              cnt_q, cnt_d;
  logic                    oe_q, ie_q, turn_q;
  logic [SYNC_STAGES-1:0]  sync_q;
  logic                    sync_src_s;
  logic                    gate_open_s;

`ifdef SIRV_SPIGPIOPORT_LOOPBACK_EN
  assign sync_src_s  = lb_en_i ? lb_data_i : ival_i;
  assign gate_open_s = ie_q | lb_en_i;
`else
  assign sync_src_s  = ival_i;
  assign gate_open_s = ie_q;
`endif

  // Next-state logic for the direction FSM and turnaround counter.
  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    cnt_d   = cnt_q;
    case (state_q)
      LANE_IN: begin
        if (oe_req_i) begin
          if (TURN_CYC == 0) begin
            state_d = LANE_OUT;
          end else begin
            state_d = LANE_TURN;
            tgt_d   = LANE_OUT;
            cnt_d   = TURN_LOAD;
          end
        end else begin
          state_d = LANE_IN;
        end
      end
      LANE_OUT: begin
        if (!oe_req_i) begin
          if (TURN_CYC == 0) begin
            state_d = LANE_IN;
          end else begin
            state_d = LANE_TURN;
            tgt_d   = LANE_IN;
            cnt_d   = TURN_LOAD;
          end
        end else begin
          state_d = LANE_OUT;
        end
      end
      LANE_TURN: begin
        // A request that flips back aborts the turnaround immediately.
        if (oe_req_i != (tgt_q == LANE_OUT)) begin
          state_d = (tgt_q == LANE_OUT) ? LANE_IN : LANE_OUT;
          cnt_d   = 3'd0;
        end else if (cnt_q == 3'd0) begin
          state_d = tgt_q;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      default: begin
        state_d = LANE_IN;
        tgt_d   = LANE_IN;
        cnt_d   = 3'd0;
      end
    endcase
  end

  // FSM state, registered pad controls and the input synchronizer chain.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= LANE_IN;
      tgt_q   <= LANE_IN;
      cnt_q   <= 3'd0;
      oe_q    <= 1'b0;
      ie_q    <= 1'b1;
      turn_q  <= 1'b0;
      sync_q  <= '0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      cnt_q   <= cnt_d;
      oe_q    <= (state_d == LANE_OUT);
      ie_q    <= (state_d == LANE_IN);
      turn_q  <= (state_d == LANE_TURN);
      sync_q  <= SYNC_STAGES'({sync_q, sync_src_s});
    end
  end

  assign oe_o   = oe_q;
  assign ie_o   = ie_q;
  assign turn_o = turn_q;
  assign data_o = sync_q[SYNC_STAGES-1] & gate_open_s;

endmodule

// File: rtl/sirv_spigpioport_param.sv
// sirv_spigpioport_param -- parameterised SPI-to-GPIO pad adapter.
// Registers sck/cs/dq outputs toward the pads, runs one direction FSM with
// turnaround per dq lane and synchronizes pad inputs back to the controller.
// Ports:
//   clock, reset                      clock, synchronous active-high reset
//   io_spi_sck/cs/dq_o/dq_oe          controller side outputs and lane direction
//   io_spi_dq_i                       synchronized, direction-gated lane inputs
//   io_pins_dq_i_ival                 pad input values
//   io_pins_{sck,cs,dq}_o_*           pad controls (oval/oe/ie/pue/ds)
//   io_turn                           lane is in turnaround
//   io_loopback                       loop dq oval into the synchronizers
// Optional feature: define SIRV_SPIGPIOPORT_LOOPBACK_EN to add io_loopback.
module sirv_spigpioport_param
  import sirv_spigpio_pkg::*;
#(
  parameter int   DQ_W        = 4,
  parameter int   CS_W        = 1,
  parameter int   TURN_CYC    = 1,
  parameter int   SYNC_STAGES = 2,
  parameter logic CS_IDLE     = 1'b1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            io_spi_sck,
  input  logic [CS_W-1:0] io_spi_cs,
  input  logic [DQ_W-1:0] io_spi_dq_o,
  input  logic [DQ_W-1:0] io_spi_dq_oe,
  output logic [DQ_W-1:0] io_spi_dq_i,
  input  logic [DQ_W-1:0] io_pins_dq_i_ival,
`ifdef SIRV_SPIGPIOPORT_LOOPBACK_EN
  input  logic            io_loopback,
`endif
  output logic            io_pins_sck_o_oval,
  output logic            io_pins_sck_o_oe,
  output logic            io_pins_sck_o_ie,
  output logic            io_pins_sck_o_pue,
  output logic            io_pins_sck_o_ds,
  output logic [CS_W-1:0] io_pins_cs_o_oval,
  output logic [CS_W-1:0] io_pins_cs_o_oe,
  output logic [CS_W-1:0] io_pins_cs_o_ie,
  output logic [CS_W-1:0] io_pins_cs_o_pue,
  output logic [CS_W-1:0] io_pins_cs_o_ds,
  output logic [DQ_W-1:0] io_pins_dq_o_oval,
  output logic [DQ_W-1:0] io_pins_dq_o_oe,
  output logic [DQ_W-1:0] io_pins_dq_o_ie,
  output logic [DQ_W-1:0] io_pins_dq_o_pue,
  output logic [DQ_W-1:0] io_pins_dq_o_ds,
  output logic [DQ_W-1:0] io_turn
);

  logic            sck_oval_q;
  logic [CS_W-1:0] cs_oval_q;
  logic [DQ_W-1:0] dq_oval_q;

  // One-cycle registered copies of the controller outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      sck_oval_q <= 1'b0;
      cs_oval_q  <= {CS_W{CS_IDLE}};
      dq_oval_q  <= '0;
    end else begin
      sck_oval_q <= io_spi_sck;
      cs_oval_q  <= io_spi_cs;
      dq_oval_q  <= io_spi_dq_o;
    end
  end

  assign io_pins_sck_o_oval = sck_oval_q;
  assign io_pins_sck_o_oe   = 1'b1;
  assign io_pins_sck_o_ie   = 1'b0;
  assign io_pins_sck_o_pue  = 1'b0;
  assign io_pins_sck_o_ds   = 1'b0;

  assign io_pins_cs_o_oval  = cs_oval_q;
  assign io_pins_cs_o_oe    = {CS_W{1'b1}};
  assign io_pins_cs_o_ie    = {CS_W{1'b0}};
  assign io_pins_cs_o_pue   = {CS_W{1'b0}};
  assign io_pins_cs_o_ds    = {CS_W{1'b0}};

  assign io_pins_dq_o_oval  = dq_oval_q;
  assign io_pins_dq_o_pue   = {DQ_W{1'b1}};
  assign io_pins_dq_o_ds    = {DQ_W{1'b0}};

  for (genvar g = 0; g < DQ_W; g++) begin : g_lane
    sirv_spigpio_lane #(
      .TURN_CYC    (TURN_CYC),
      .SYNC_STAGES (SYNC_STAGES)
    ) u_lane (
      .clk_i     (clock),
      .rst_i     (reset),
      .oe_req_i  (io_spi_dq_oe[g]),
      .ival_i    (io_pins_dq_i_ival[g]),
`ifdef SIRV_SPIGPIOPORT_LOOPBACK_EN
      .lb_en_i   (io_loopback),
      .lb_data_i (dq_oval_q[g]),
`endif
      .oe_o      (io_pins_dq_o_oe[g]),
      .ie_o      (io_pins_dq_o_ie[g]),
      .turn_o    (io_turn[g]),
      .data_o    (io_spi_dq_i[g])
    );
  end

endmodule

// File: tb/tb_sirv_spigpioport_param.sv
// Bench for sirv_spigpioport_param: three instances sharing one stimulus
// stream (TURN_CYC = 3, 0 and 5). Expected values are queued with the cycle
// they are due at when stimulus is applied and compared on the falling edge.
module tb_sirv_spigpioport_param;

  localparam int DQ_W = 4;
  localparam int CS_W = 2;

  localparam int PR_CS    = 0;
  localparam int PR_SCK   = 1;
  localparam int PR_DQOV  = 2;
  localparam int PR_OE    = 3;
  localparam int PR_IE    = 4;
  localparam int PR_DQI   = 5;
  localparam int PR_TURN  = 6;
  localparam int PR_CONST = 7;

  localparam int DA = 0;  // TURN_CYC = 3
  localparam int DB = 1;  // TURN_CYC = 0
  localparam int DC = 2;  // TURN_CYC = 5, CS_IDLE = 0

  logic            clock = 1'b0;
  logic            reset;
  logic            sck;
  logic [CS_W-1:0] cs;
  logic [DQ_W-1:0] dq_o, dq_oe, ival;
  logic            loopback;

  logic [2:0][DQ_W-1:0] dqi, turn, dq_oval, dq_oe_p, dq_ie_p, dq_pue, dq_ds;
  logic [2:0]           sck_oval, sck_oe, sck_ie, sck_pue, sck_ds;
  logic [2:0][CS_W-1:0] cs_oval, cs_oe, cs_ie, cs_pue, cs_ds;

  typedef struct {
    int          due;
    int          probe;
    logic [31:0] exp;
    string       tag;
  } sb_item_t;

  sb_item_t sb_q[$];
  int       cyc = -4;
  bit       run = 1'b0;
  int       n_cmp = 0;
  int       n_bad = 0;

  always #5 clock = ~clock;

  sirv_spigpioport_param #(.DQ_W(DQ_W), .CS_W(CS_W), .TURN_CYC(3), .SYNC_STAGES(2), .CS_IDLE(1'b1)) u_dut_a (
    .clock(clock), .reset(reset), .io_spi_sck(sck), .io_spi_cs(cs), .io_spi_dq_o(dq_o),
    .io_spi_dq_oe(dq_oe), .io_spi_dq_i(dqi[0]), .io_pins_dq_i_ival(ival),
`ifdef SIRV_SPIGPIOPORT_LOOPBACK_EN
    .io_loopback(loopback),
`endif
    .io_pins_sck_o_oval(sck_oval[0]), .io_pins_sck_o_oe(sck_oe[0]), .io_pins_sck_o_ie(sck_ie[0]),
    .io_pins_sck_o_pue(sck_pue[0]), .io_pins_sck_o_ds(sck_ds[0]),
    .io_pins_cs_o_oval(cs_oval[0]), .io_pins_cs_o_oe(cs_oe[0]), .io_pins_cs_o_ie(cs_ie[0]),
    .io_pins_cs_o_pue(cs_pue[0]), .io_pins_cs_o_ds(cs_ds[0]),
    .io_pins_dq_o_oval(dq_oval[0]), .io_pins_dq_o_oe(dq_oe_p[0]), .io_pins_dq_o_ie(dq_ie_p[0]),
    .io_pins_dq_o_pue(dq_pue[0]), .io_pins_dq_o_ds(dq_ds[0]), .io_turn(turn[0])
  );

  sirv_spigpioport_param #(.DQ_W(DQ_W), .CS_W(CS_W), .TURN_CYC(0), .SYNC_STAGES(2), .CS_IDLE(1'b1)) u_dut_b (
    .clock(clock), .reset(reset), .io_spi_sck(sck), .io_spi_cs(cs), .io_spi_dq_o(dq_o),
    .io_spi_dq_oe(dq_oe), .io_spi_dq_i(dqi[1]), .io_pins_dq_i_ival(ival),
`ifdef SIRV_SPIGPIOPORT_LOOPBACK_EN
    .io_loopback(loopback),
`endif
    .io_pins_sck_o_oval(sck_oval[1]), .io_pins_sck_o_oe(sck_oe[1]), .io_pins_sck_o_ie(sck_ie[1]),
    .io_pins_sck_o_pue(sck_pue[1]), .io_pins_sck_o_ds(sck_ds[1]),
    .io_pins_cs_o_oval(cs_oval[1]), .io_pins_cs_o_oe(cs_oe[1]), .io_pins_cs_o_ie(cs_ie[1]),
    .io_pins_cs_o_pue(cs_pue[1]), .io_pins_cs_o_ds(cs_ds[1]),
    .io_pins_dq_o_oval(dq_oval[1]), .io_pins_dq_o_oe(dq_oe_p[1]), .io_pins_dq_o_ie(dq_ie_p[1]),
    .io_pins_dq_o_pue(dq_pue[1]), .io_pins_dq_o_ds(dq_ds[1]), .io_turn(turn[1])
  );

  sirv_spigpioport_param #(.DQ_W(DQ_W), .CS_W(CS_W), .TURN_CYC(5), .SYNC_STAGES(2), .CS_IDLE(1'b0)) u_dut_c (
    .clock(clock), .reset(reset), .io_spi_sck(sck), .io_spi_cs(cs), .io_spi_dq_o(dq_o),
    .io_spi_dq_oe(dq_oe), .io_spi_dq_i(dqi[2]), .io_pins_dq_i_ival(ival),
`ifdef SIRV_SPIGPIOPORT_LOOPBACK_EN
    .io_loopback(loopback),
`endif
    .io_pins_sck_o_oval(sck_oval[2]), .io_pins_sck_o_oe(sck_oe[2]), .io_pins_sck_o_ie(sck_ie[2]),
    .io_pins_sck_o_pue(sck_pue[2]), .io_pins_sck_o_ds(sck_ds[2]),
    .io_pins_cs_o_oval(cs_oval[2]), .io_pins_cs_o_oe(cs_oe[2]), .io_pins_cs_o_ie(cs_ie[2]),
    .io_pins_cs_o_pue(cs_pue[2]), .io_pins_cs_o_ds(cs_ds[2]),
    .io_pins_dq_o_oval(dq_oval[2]), .io_pins_dq_o_oe(dq_oe_p[2]), .io_pins_dq_o_ie(dq_ie_p[2]),
    .io_pins_dq_o_pue(dq_pue[2]), .io_pins_dq_o_ds(dq_ds[2]), .io_turn(turn[2])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_at(input int due, input int dut, input int kind,
                           input logic [31:0] exp, input string tag);
    sb_item_t it;
    it.due   = due;
    it.probe = dut * 8 + kind;
    it.exp   = exp;
    it.tag   = tag;
    sb_q.push_back(it);
  endtask

  function automatic logic [31:0] sample(input int p);
    int d;
    d = p / 8;
    case (p % 8)
      PR_CS:    return 32'(cs_oval[d]);
      PR_SCK:   return 32'(sck_oval[d]);
      PR_DQOV:  return 32'(dq_oval[d]);
      PR_OE:    return 32'(dq_oe_p[d]);
      PR_IE:    return 32'(dq_ie_p[d]);
      PR_DQI:   return 32'(dqi[d]);
      PR_TURN:  return 32'(turn[d]);
      PR_CONST: return 32'({sck_oe[d], sck_ie[d], sck_pue[d], sck_ds[d],
                            cs_oe[d], cs_ie[d], cs_pue[d], cs_ds[d], dq_pue[d], dq_ds[d]});
      default:  return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick();
  endtask

  // Falling-edge scoreboard drain plus per-cycle invariants.
  always @(negedge clock) begin
    if (run) begin
      for (int i = sb_q.size() - 1; i >= 0; i--) begin
        if (sb_q[i].due == cyc) begin
          chk($sformatf("%s@%0d", sb_q[i].tag, cyc), sample(sb_q[i].probe), sb_q[i].exp);
          sb_q.delete(i);
        end
      end
      for (int d = 0; d < 3; d++) begin
        chk($sformatf("oe_and_ie_dut%0d@%0d", d, cyc), 32'(dq_oe_p[d] & dq_ie_p[d]), 32'h0);
      end
      chk($sformatf("turn_tc0@%0d", cyc), 32'(turn[1]), 32'h0);
    end
  end

  initial begin
    logic v;
    reset    = 1'b1;
    sck      = 1'b0;
    cs       = 2'b00;
    dq_o     = 4'h0;
    dq_oe    = 4'h0;
    ival     = 4'hF;
    loopback = 1'b0;
    wait_until(-1);
    run = 1'b1;

    // Reset state (cycle -1 is the last cycle with reset sampled high).
    expect_at(-1, DA, PR_CS,    32'h3,     "rst_cs_idle1");
    expect_at(-1, DC, PR_CS,    32'h0,     "rst_cs_idle0");
    expect_at(-1, DA, PR_OE,    32'h0,     "rst_dq_oe");
    expect_at(-1, DA, PR_IE,    32'hF,     "rst_dq_ie");
    expect_at(-1, DA, PR_DQI,   32'h0,     "rst_dq_i");
    expect_at(-1, DA, PR_TURN,  32'h0,     "rst_turn");
    expect_at(-1, DA, PR_SCK,   32'h0,     "rst_sck");
    expect_at(-1, DA, PR_DQOV,  32'h0,     "rst_dq_oval");
    expect_at(-1, DA, PR_CONST, 32'h8C0F0, "pad_consts");
    reset = 1'b0;
    cs    = 2'b01;
    sck   = 1'b1;
    dq_o  = 4'h5;
    expect_at(0, DA, PR_CS,   32'h1, "cs_copy");
    expect_at(0, DA, PR_SCK,  32'h1, "sck_copy");
    expect_at(0, DA, PR_DQOV, 32'h5, "dq_oval_copy");
    expect_at(0, DA, PR_DQI,  32'h0, "dq_i_first_cycle");
    expect_at(1, DA, PR_DQI,  32'hF, "sync_after_rst");
    expect_at(2, DA, PR_DQI,  32'h0, "sync_clear");
    tick();
    ival = 4'h0;

    // Lane 0 request 0->1 at cycle 10.
    wait_until(10);
    dq_oe[0] = 1'b1;
    for (int c = 11; c <= 13; c++) begin
      expect_at(c, DA, PR_TURN, 32'h1, "tc3_turn");
      expect_at(c, DA, PR_OE,   32'h0, "tc3_oe_low");
    end
    for (int c = 11; c <= 14; c++) expect_at(c, DA, PR_IE, 32'hE, "tc3_ie_low");
    expect_at(14, DA, PR_TURN, 32'h0, "tc3_turn_end");
    expect_at(14, DA, PR_OE,   32'h1, "tc3_oe_high");
    expect_at(11, DB, PR_OE,   32'h1, "tc0_direct_out");
    expect_at(15, DC, PR_TURN, 32'h1, "tc5_turn_last");
    expect_at(15, DC, PR_OE,   32'h0, "tc5_oe_low");
    expect_at(16, DC, PR_OE,   32'h1, "tc5_oe_high");

    // Lane 1 input pulse while IN, then while OUT.
    wait_until(20);
    ival = 4'b0010;
    expect_at(21, DA, PR_DQI, 32'h0, "sync_pre");
    expect_at(22, DA, PR_DQI, 32'h2, "sync_pulse");
    expect_at(23, DA, PR_DQI, 32'h0, "sync_post");
    tick();
    ival = 4'h0;
    wait_until(24);
    dq_oe[1] = 1'b1;
    expect_at(27, DA, PR_OE, 32'h1, "lane1_turning");
    expect_at(28, DA, PR_OE, 32'h3, "lane1_out");
    wait_until(30);
    ival = 4'b0011;
    for (int c = 31; c <= 33; c++) expect_at(c, DA, PR_DQI, 32'h0, "gated_out");
    tick();
    ival = 4'h0;

    // Lane 2 request toggled every cycle; TURN_CYC=0 instance follows 1 cycle late.
    wait_until(40);
    for (int k = 40; k < 50; k++) begin
      v = ~cyc[0];
      dq_oe[2] = v;
      expect_at(k + 1, DB, PR_OE, 32'({1'b0, v, 2'b11}), "tc0_follow");
      tick();
    end
    expect_at(51, DB, PR_OE, 32'h3, "tc0_settle");

    // Lane 3 revert during turnaround, then a full turnaround.
    wait_until(60);
    dq_oe[3] = 1'b1;
    expect_at(61, DC, PR_TURN, 32'h8, "rev_turn1");
    expect_at(61, DC, PR_IE,   32'h4, "rev_ie1");
    expect_at(62, DC, PR_TURN, 32'h8, "rev_turn2");
    tick();
    tick();
    dq_oe[3] = 1'b0;
    expect_at(63, DC, PR_TURN, 32'h0, "rev_turn_off");
    expect_at(63, DC, PR_IE,   32'hC, "rev_back_in");
    expect_at(63, DC, PR_OE,   32'h3, "rev_oe");
    expect_at(64, DC, PR_IE,   32'hC, "rev_stay_in");
    expect_at(63, DA, PR_IE,   32'hC, "rev_back_in_tc3");
    wait_until(70);
    dq_oe[3] = 1'b1;
    expect_at(75, DC, PR_OE,   32'h3, "full_turn_oe_low");
    expect_at(75, DC, PR_TURN, 32'h8, "full_turn_last");
    expect_at(76, DC, PR_OE,   32'hB, "full_turn_out");

    // Reset asserted mid-turnaround.
    wait_until(80);
    dq_oe[3] = 1'b0;
    wait_until(82);
    reset = 1'b1;
    expect_at(82, DC, PR_TURN, 32'h8, "pre_rst_turn");
    expect_at(83, DC, PR_TURN, 32'h0, "rst_turn_abort");
    expect_at(83, DC, PR_IE,   32'hF, "rst_lane_in");
    expect_at(83, DC, PR_OE,   32'h0, "rst_lane_oe");
    expect_at(83, DC, PR_CS,   32'h0, "rst_cs_idle0_mid");
    expect_at(83, DA, PR_CS,   32'h3, "rst_cs_idle1_mid");
    expect_at(83, DA, PR_SCK,  32'h0, "rst_sck_mid");
    tick();
    reset = 1'b0;
    expect_at(84, DC, PR_CS, 32'h1, "cs_after_rst");

`ifdef SIRV_SPIGPIOPORT_LOOPBACK_EN
    wait_until(90);
    loopback = 1'b1;
    dq_o     = 4'hA;
    dq_oe    = 4'hF;
    expect_at(93, DA, PR_DQI, 32'hA, "loopback");
`endif

    wait_until(100);
    chk("sb_drain", 32'(sb_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
